fetch_pc_unit: RTL and testbench

Program-counter generator for the instruction-fetch stage. It holds the architectural fetch PC and issues it to instruction memory over a valid/ready request handshake. It accepts branch/jal/jalr redirects from execute, queues a redirect that arrives while a request is blocked, and halts in a trap state on a misaligned target. It is the parametrised, stall- and handshake-aware successor to the single-cycle PC register.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/pc_target_calc.sv | 43 ++++
 rtl/fetch_pc_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch PC generator.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JALR   = 2'b10
  } pcsrc_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation and alignment check.
module pc_target_calc
  import fetch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit COMPRESSED = 1'b0
) (
  input  logic [1:0]       src,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] alu,
  output logic             src_valid,
  output logic [WIDTH-1:0] target,
  output logic             misaligned
);

  always_comb begin
    src_valid = 1'b0;
    target    = '0;
    case (src)
      PCSRC_BRANCH: begin
        src_valid = 1'b1;
        target    = base + imm;
      end
      PCSRC_JALR: begin
        src_valid = 1'b1;
        target    = {alu[WIDTH-1:1], 1'b0};
      end
      default: begin
        src_valid = 1'b0;
        target    = '0;
      end
    endcase
  end

  // Bit 0 is only ever set by a branch; bit 1 matters only without compressed instructions.
  if (COMPRESSED) begin : g_half_align
    assign misaligned = target[0];
  end else begin : g_word_align
    assign misaligned = target[1] | target[0];
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with valid/ready request handshake, redirect queue and misalignment trap.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h100,
  parameter bit               COMPRESSED   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_src,
  input  logic [WIDTH-1:0] redirect_base,
  input  logic [WIDTH-1:0] redirect_imm,
  input  logic [WIDTH-1:0] redirect_alu,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             trap_valid,
  output logic [WIDTH-1:0] trap_addr,
  input  logic             trap_ack
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pending_q, pending_d;
  logic             qvalid_q, qvalid_d;
  logic [WIDTH-1:0] qtarget_q, qtarget_d;
  logic             qmis_q, qmis_d;
  logic             trap_valid_q, trap_valid_d;
  logic [WIDTH-1:0] trap_addr_q, trap_addr_d;

  logic             calc_valid;
  logic [WIDTH-1:0] calc_target;
  logic             calc_mis;
  logic             redir_eff;
  logic             fire;
  logic             hold;
  logic             apply_en;
  logic [WIDTH-1:0] apply_target;
  logic             apply_mis;

  pc_target_calc #(
    .WIDTH      (WIDTH),
    .COMPRESSED (COMPRESSED)
  ) u_target (
    .src        (redirect_src),
    .base       (redirect_base),
    .imm        (redirect_imm),
    .alu        (redirect_alu),
    .src_valid  (calc_valid),
    .target     (calc_target),
    .misaligned (calc_mis)
  );

  // A request held by imem keeps req_valid up through stall until it fires.
  assign req_valid = !rst && (state_q == RUN) && (!stall || pending_q);
  assign fire      = req_valid && req_ready;
  assign hold      = req_valid && !req_ready;
  assign redir_eff = redirect_valid && calc_valid && (state_q == RUN);

  assign req_pc     = pc_q;
  assign pc_plus4   = pc_q + WIDTH'(INSTR_BYTES);
  assign trap_valid = trap_valid_q;
  assign trap_addr  = trap_addr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    qvalid_d     = qvalid_q;
    qtarget_d    = qtarget_q;
    qmis_d       = qmis_q;
    trap_valid_d = trap_valid_q;
    trap_addr_d  = trap_addr_q;
    apply_en     = 1'b0;
    apply_target = qtarget_q;
    apply_mis    = qmis_q;

    if (state_q == TRAP) begin
      if (trap_ack) begin
        pc_d         = TRAP_VECTOR;
        trap_valid_d = 1'b0;
        state_d      = RUN;
      end
    end else if (fire) begin
      pending_d = 1'b0;
      qvalid_d  = 1'b0;
      if (redir_eff) begin
        apply_en     = 1'b1;
        apply_target = calc_target;
        apply_mis    = calc_mis;
      end else if (qvalid_q) begin
        apply_en = 1'b1;
      end else begin
        pc_d = pc_q + WIDTH'(INSTR_BYTES);
      end
    end else if (hold) begin
      pending_d = 1'b1;
      if (redir_eff) begin
        qvalid_d  = 1'b1;
        qtarget_d = calc_target;
        qmis_d    = calc_mis;
      end
    end else if (redir_eff) begin
      apply_en     = 1'b1;
      apply_target = calc_target;
      apply_mis    = calc_mis;
    end

    // A misaligned target never reaches the PC; it parks in trap_addr instead.
    if (apply_en) begin
      if (apply_mis) begin
        state_d      = TRAP;
        trap_valid_d = 1'b1;
        trap_addr_d  = apply_target;
        qvalid_d     = 1'b0;
      end else begin
        pc_d = apply_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      pending_q    <= 1'b0;
      qvalid_q     <= 1'b0;
      qtarget_q    <= '0;
      qmis_q       <= 1'b0;
      trap_valid_q <= 1'b0;
      trap_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      qvalid_q     <= qvalid_d;
      qtarget_q    <= qtarget_d;
      qmis_q       <= qmis_d;
      trap_valid_q <= trap_valid_d;
      trap_addr_q  <= trap_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: word-aligned and compressed instances driven in lockstep against a reference model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_src = 2'b00;
  logic [31:0] redirect_base = '0;
  logic [31:0] redirect_imm = '0;
  logic [31:0] redirect_alu = '0;
  logic        req_ready = 1'b0;
  logic        trap_ack = 1'b0;

  logic [1:0]  rv_o;
  logic [1:0]  tv_o;
  logic [31:0] pc_o  [2];
  logic [31:0] p4_o  [2];
  logic [31:0] ta_o  [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per instance (0: word alignment, 1: compressed)
  logic [31:0] m_pc [2];
  logic [31:0] m_ta [2];
  logic [31:0] m_qt [2];
  bit          m_pend [2];
  bit          m_trap [2];
  bit          m_qh [2];

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .COMPRESSED(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_src(redirect_src),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm), .redirect_alu(redirect_alu),
    .req_valid(rv_o[0]), .req_ready(req_ready), .req_pc(pc_o[0]), .pc_plus4(p4_o[0]),
    .trap_valid(tv_o[0]), .trap_addr(ta_o[0]), .trap_ack(trap_ack)
  );

  fetch_pc_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .COMPRESSED(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_src(redirect_src),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm), .redirect_alu(redirect_alu),
    .req_valid(rv_o[1]), .req_ready(req_ready), .req_pc(pc_o[1]), .pc_plus4(p4_o[1]),
    .trap_valid(tv_o[1]), .trap_addr(ta_o[1]), .trap_ack(trap_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_ta[k] = 32'h0; m_qt[k] = 32'h0;
      m_pend[k] = 0; m_trap[k] = 0; m_qh[k] = 0;
    end
  endtask

  function automatic bit model_req_valid(input int k);
    return !m_trap[k] && (!stall || m_pend[k]);
  endfunction

  task automatic model_go(input int k, input logic [31:0] t);
    bit bad;
    bad = (k == 1) ? (t % 2 != 0) : (t % 4 != 0);
    if (bad) begin
      m_trap[k] = 1; m_ta[k] = t; m_qh[k] = 0;
    end else begin
      m_pc[k] = t;
    end
  endtask

  task automatic model_step(input int k);
    bit redir, rq;
    logic [31:0] t;
    if (m_trap[k]) begin
      if (trap_ack) begin
        m_pc[k] = 32'h100;
        m_trap[k] = 0;
      end
      return;
    end
    redir = redirect_valid && (redirect_src == 2'd1 || redirect_src == 2'd2);
    t = (redirect_src == 2'd1) ? redirect_base + redirect_imm : redirect_alu & ~32'h1;
    rq = model_req_valid(k);
    if (rq && req_ready) begin
      m_pend[k] = 0;
      if (redir) model_go(k, t);
      else if (m_qh[k]) model_go(k, m_qt[k]);
      else m_pc[k] = m_pc[k] + 32'd4;
      m_qh[k] = 0;
    end else if (rq) begin
      m_pend[k] = 1;
      if (redir) begin
        m_qh[k] = 1;
        m_qt[k] = t;
      end
    end else if (redir) begin
      model_go(k, t);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("d%0d_req_valid", k), {31'b0, rv_o[k]}, {31'b0, model_req_valid(k)});
      check_eq($sformatf("d%0d_req_pc", k), pc_o[k], m_pc[k]);
      check_eq($sformatf("d%0d_pc_plus4", k), p4_o[k], m_pc[k] + 32'd4);
      check_eq($sformatf("d%0d_trap_valid", k), {31'b0, tv_o[k]}, {31'b0, m_trap[k]});
      check_eq($sformatf("d%0d_trap_addr", k), ta_o[k], m_ta[k]);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance model at the edge.
  task automatic step(input bit s, input bit rdy, input bit rv, input logic [1:0] src,
                      input logic [31:0] b, input logic [31:0] imm, input logic [31:0] a,
                      input bit ack);
    stall = s; req_ready = rdy; redirect_valid = rv; redirect_src = src;
    redirect_base = b; redirect_imm = imm; redirect_alu = a; trap_ack = ack;
    #4;
    check_outputs();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  initial begin
    logic [31:0] rb, ri, ra;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_req_valid", {31'b0, rv_o[k]}, 32'h0);
      check_eq("rst_req_pc", pc_o[k], 32'h0);
      check_eq("rst_trap_valid", {31'b0, tv_o[k]}, 32'h0);
      check_eq("rst_trap_addr", ta_o[k], 32'h0);
    end
    rst = 1'b0;

    // Back-to-back sequential fetch
    for (int n = 0; n < 4; n++) begin
      check_eq("seq_pc", pc_o[0], 32'(4 * n));
      step(0, 1, 0, 2'b00, 0, 0, 0, 0);
    end
    check_eq("seq_pc_end", pc_o[0], 32'h10);

    // Redirect during a held request takes effect after the fire
    step(0, 0, 1, 2'b01, 32'h10, 32'h40, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0, 0);
    check_eq("hold_pc_stable", pc_o[0], 32'h10);
    step(1, 1, 0, 2'b00, 0, 0, 0, 0);
    check_eq("hold_redirect_pc0", pc_o[0], 32'h50);
    check_eq("hold_redirect_pc1", pc_o[1], 32'h50);

    // Stalled jalr to 0x203: word instance traps on 0x202, compressed one jumps
    step(1, 1, 1, 2'b10, 0, 0, 32'h203, 0);
    check_eq("stall_no_req", {31'b0, rv_o[1]}, 32'h0);
    check_eq("jalr_trap_valid0", {31'b0, tv_o[0]}, 32'h1);
    check_eq("jalr_trap_addr0", ta_o[0], 32'h202);
    check_eq("jalr_pc0_kept", pc_o[0], 32'h50);
    check_eq("jalr_pc1", pc_o[1], 32'h202);
    step(1, 0, 0, 2'b00, 0, 0, 0, 1);
    check_eq("ack_pc0", pc_o[0], 32'h100);
    check_eq("ack_trap_clear0", {31'b0, tv_o[0]}, 32'h0);

    // Half-word and byte-odd branch targets
    step(1, 0, 1, 2'b01, 32'h100, 32'h2, 0, 0);
    check_eq("br102_pc1", pc_o[1], 32'h102);
    check_eq("br102_trap0", ta_o[0], 32'h102);
    step(1, 0, 0, 2'b00, 0, 0, 0, 1);
    step(1, 0, 1, 2'b01, 32'h100, 32'h1, 0, 0);
    check_eq("br101_trap1", {31'b0, tv_o[1]}, 32'h1);
    check_eq("br101_addr1", ta_o[1], 32'h101);
    step(1, 0, 0, 2'b00, 0, 0, 0, 1);
    check_eq("br101_ack_pc1", pc_o[1], 32'h100);

    // PC+4 wrap
    step(1, 0, 1, 2'b10, 0, 0, 32'hFFFF_FFFC, 0);
    check_eq("wrap_pre", pc_o[0], 32'hFFFF_FFFC);
    step(0, 1, 0, 2'b00, 0, 0, 0, 0);
    check_eq("wrap_pc0", pc_o[0], 32'h0);
    check_eq("wrap_pc1", pc_o[1], 32'h0);

    // Reset in the middle of a hold with a queued redirect
    step(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 0, 1, 2'b01, 32'h0, 32'h80, 0, 0);
    redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("midrst_pc", pc_o[k], 32'h0);
      check_eq("midrst_req_valid", {31'b0, rv_o[k]}, 32'h0);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 0, 0, 0);
    check_eq("midrst_resume", pc_o[0], 32'h4);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rb = $urandom() & 32'hFFFF_FFFC;
      ri = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : (32'($urandom_range(0, 255)) << 2);
      ra = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), rb, ri, ra, $urandom_range(0, 9) < 4);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
